// File: rtl/decrypt_unit.sv
// -----------------------------------------------------------------------------
// decrypt_unit
//
// Iterative 8-bit decryptor, the receive-side inverse of the keyed byte
// cipher. The forward cipher does x = rotl(x,1) ^ k_r with k_{r+1} = rotl(k_r,1).
// This block runs it backwards:
//   start:          x = C, k = rotl(key, ROUNDS-1)
//   ROUNDS times:   x = rotr(x ^ k, 1), k = rotr(k, 1)
// It completes one inverse round per clock.
//
// Parameters:
//   ROUNDS      number of cipher rounds (1..8). It must match the encryptor.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       request strobe; only looked at while IDLE
//   enc_number  ciphertext byte, captured on the accepting edge
//   key         cipher key, captured on the accepting edge
//   busy        high while rounds are in progress (RUN)
//   done        registered one-cycle pulse when number is updated
//   number      recovered plaintext; holds until the next result
//
// Handshake: start is a strobe with no ready. A start seen in IDLE is accepted
// on that edge. A start seen in RUN is dropped, and nothing queues it.
// Back-to-back use is allowed because the done cycle is already IDLE.
//
// Optional feature (macro DECRYPT_BYPASS_EN):
//   When this macro is defined and an accepted request carries key == 8'h00,
//   the rounds reduce to a pure rotate. The result rotr(enc_number, ROUNDS%8)
//   is written on the accepting edge and RUN is skipped.
// -----------------------------------------------------------------------------
module decrypt_unit #(
  parameter int ROUNDS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] enc_number,
  input  logic [7:0] key,
  output logic       busy,
  output logic       done,
  output logic [7:0] number
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The first inverse round uses the last forward round key.
  localparam logic [2:0] KEY_ROT  = 3'(ROUNDS - 1);
  localparam logic [2:0] CNT_INIT = 3'(ROUNDS - 1);
`ifdef DECRYPT_BYPASS_EN
  localparam logic [2:0] BYP_ROT  = 3'(ROUNDS % 8);
`endif

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] t;
    t = {v, v} << s;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] t;
    t = {v, v} >> s;
    return t[7:0];
  endfunction

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] k_q, k_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] number_q, number_d;
  logic       done_q, done_d;
  logic [7:0] x_round;

  // One inverse round of the data path.
  assign x_round = rotr8(x_q ^ k_q, 3'd1);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    number_d = number_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DECRYPT_BYPASS_EN
          if (key == 8'h00) begin
            // A zero key makes every XOR a no-op, so only the rotate remains.
            number_d = rotr8(enc_number, BYP_ROT);
            done_d   = 1'b1;
          end else begin
            x_d     = enc_number;
            k_d     = rotl8(key, KEY_ROT);
            cnt_d   = CNT_INIT;
            state_d = RUN;
          end
`else
          x_d     = enc_number;
          k_d     = rotl8(key, KEY_ROT);
          cnt_d   = CNT_INIT;
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        x_d = x_round;
        k_d = rotr8(k_q, 3'd1);
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          number_d = x_round;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= 8'h00;
      k_q      <= 8'h00;
      cnt_q    <= 3'd0;
      number_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign number = number_q;

endmodule

// File: tb/tb_decrypt_unit.sv
// -----------------------------------------------------------------------------
// tb_decrypt_unit
//
// Directed and randomized checks of decrypt_unit. Three instances run with
// ROUNDS = 4, 1 and 8. Index 0 (ROUNDS=4) carries the directed vectors.
// Expected plaintexts are either hand-computed constants or come from a
// forward-cipher model applied to a random plaintext.
// -----------------------------------------------------------------------------
module tb_decrypt_unit;

  localparam int NU = 3;
  int rnds[NU] = '{4, 1, 8};

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       start_v  [NU];
  logic [7:0] enc_v    [NU];
  logic [7:0] key_v    [NU];
  logic       busy_v   [NU];
  logic       done_v   [NU];
  logic [7:0] number_v [NU];

  decrypt_unit #(.ROUNDS(4)) u_dut4 (
    .clock(clock), .reset(reset), .start(start_v[0]), .enc_number(enc_v[0]),
    .key(key_v[0]), .busy(busy_v[0]), .done(done_v[0]), .number(number_v[0])
  );
  decrypt_unit #(.ROUNDS(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .enc_number(enc_v[1]),
    .key(key_v[1]), .busy(busy_v[1]), .done(done_v[1]), .number(number_v[1])
  );
  decrypt_unit #(.ROUNDS(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(start_v[2]), .enc_number(enc_v[2]),
    .key(key_v[2]), .busy(busy_v[2]), .done(done_v[2]), .number(number_v[2])
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Forward cipher model.
  function automatic logic [7:0] fwd(input logic [7:0] p, input logic [7:0] kk, input int r);
    logic [7:0] x, k;
    x = p;
    k = kk;
    for (int i = 0; i < r; i++) begin
      x = {x[6:0], x[7]} ^ k;
      k = {k[6:0], k[7]};
    end
    return x;
  endfunction

  function automatic int exp_latency(input int u, input logic [7:0] kk);
    int l;
    l = rnds[u];
`ifdef DECRYPT_BYPASS_EN
    if (kk == 8'h00) l = 0;
`endif
    return l;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Wait up to budget edges for done, counting edges and busy-high cycles.
  task automatic wait_done(input int u, input int budget, input string tag,
                           output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done_v[u] && lat < budget) begin
      if (busy_v[u]) bcnt++;
      cycle();
      lat++;
    end
    if (!done_v[u]) check({tag, "_timeout"}, 32'(done_v[u]), 32'd1);
  endtask

  // Launch one request and return positioned in its done cycle.
  task automatic run_op(input int u, input logic [7:0] c, input logic [7:0] kk,
                        input string tag);
    int lat, bcnt, elat;
    logic [7:0] exp;
    elat = exp_latency(u, kk);
    start_v[u] = 1'b1;
    enc_v[u]   = c;
    key_v[u]   = kk;
    cycle();
    start_v[u] = 1'b0;
    enc_v[u]   = 8'($urandom);
    key_v[u]   = 8'($urandom);
    wait_done(u, 20, tag, lat, bcnt);
    exp = exp_q.pop_front();
    check({tag, "_number"}, 32'(number_v[u]), 32'(exp));
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(elat));
    check({tag, "_busy_at_done"}, 32'(busy_v[u]), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bcnt, pulses;
    logic [7:0] p, kk;

    for (int u = 0; u < NU; u++) begin
      start_v[u] = 1'b0;
      enc_v[u]   = 8'h00;
      key_v[u]   = 8'h00;
    end
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    for (int u = 0; u < NU; u++) begin
      check($sformatf("reset_busy_u%0d", u), 32'(busy_v[u]), 32'd0);
      check($sformatf("reset_done_u%0d", u), 32'(done_v[u]), 32'd0);
      check($sformatf("reset_number_u%0d", u), 32'(number_v[u]), 32'h00);
    end
    cycle();

    // Basic vector.
    exp_q.push_back(8'h46);
    run_op(0, 8'h64, 8'h93, "basic");
    cycle();
    check("basic_single_pulse", 32'(done_v[0]), 32'd0);
    check("basic_number_hold", 32'(number_v[0]), 32'h46);

    // Back-to-back: the second start is driven in the first done cycle.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h46);
    run_op(0, 8'h5A, 8'h5A, "b2b_first");
    run_op(0, 8'h64, 8'h93, "b2b_second");
    cycle();

    // Zero key: full latency, or a same-edge result when bypass is built in.
    exp_q.push_back(8'hC9);
    run_op(0, 8'h9C, 8'h00, "zero_key");
    cycle();
    check("zero_key_single_pulse", 32'(done_v[0]), 32'd0);

    // Start pulses during RUN are ignored.
    start_v[0] = 1'b1;
    enc_v[0]   = 8'h64;
    key_v[0]   = 8'h93;
    cycle();
    enc_v[0]   = 8'h11;
    key_v[0]   = 8'h22;
    cycle();
    cycle();
    start_v[0] = 1'b0;
    wait_done(0, 20, "ignore", lat, bcnt);
    check("ignore_number", 32'(number_v[0]), 32'h46);
    check("ignore_latency", 32'(lat), 32'd2);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (done_v[0]) pulses++;
    end
    check("ignore_extra_pulses", 32'(pulses), 32'd0);

    // Reset mid-RUN aborts and leaves no done pulse behind.
    start_v[0] = 1'b1;
    enc_v[0]   = 8'h5A;
    key_v[0]   = 8'h5A;
    cycle();
    start_v[0] = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_done", 32'(done_v[0]), 32'd0);
    check("abort_number", 32'(number_v[0]), 32'h00);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (done_v[0]) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    exp_q.push_back(8'h46);
    run_op(0, 8'h64, 8'h93, "after_abort");
    cycle();

    // Randomized round-trip for each ROUNDS value, plus one forced zero key.
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 16; i++) begin
        p  = 8'($urandom_range(0, 255));
        kk = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        exp_q.push_back(p);
        run_op(u, fwd(p, kk, rnds[u]), kk, $sformatf("rand_u%0d_%0d", u, i));
        if (i % 3 == 0) cycle();
      end
      cycle();
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
